hist_frame_ctrl: RTL
====================

HIST_FRAME_CTRL -- requirements
Module: hist_frame_ctrl

Interface
REQ-001 SHALL have parameter PIPE_LAT, default 4, meaning cycles from sweep_addr issue to final LUT write in the equalisation datapath.
REQ-002 SHALL have parameter BINS, default 256, meaning histogram bin count; sweep and clear lengths equal BINS.
REQ-003 SHALL have port clk, input, 1, system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port frame_vs, input, 1, field sync; high for the whole active frame, low during frame gap.
REQ-006 SHALL have port frame_de, input, 1, pixel data enable.
REQ-007 SHALL have port acc_en, output, 1, histogram accumulate enable (frame_de gated by state).
REQ-008 SHALL have port sweep_en, output, 1, CDF sweep read strobe to histogram RAM.
REQ-009 SHALL have port sweep_addr, output, 8, CDF sweep bin address.
REQ-010 SHALL have port clr_en, output, 1, histogram RAM zero-write strobe.
REQ-011 SHALL have port clr_addr, output, 8, histogram RAM clear address.
REQ-012 SHALL have port lut_bank, output, 1, ping-pong LUT bank used for pixel mapping; sweep writes the other bank.
REQ-013 SHALL have port lut_valid, output, 1, high once at least one LUT has been completed.
REQ-014 SHALL have port busy, output, 1, high in any state other than WAIT_FRAME and ACCUM.
REQ-015 SHALL have port overrun, output, 1, one-cycle pulse when a frame starts before sequencing completes.
REQ-016 SHALL have port frame_cnt, output, 16, completed-LUT counter (see Configuration).
REQ-017 SHALL have port overrun_cnt, output, 8, overrun counter (see Configuration).

Function
REQ-018 SHALL implement FSM states WAIT_FRAME, ACCUM, SWEEP, DRAIN, CLEAR, SWAP.
REQ-019 SHALL leave WAIT_FRAME for ACCUM on the frame_vs rising edge, which is detected from a one-cycle-registered copy of frame_vs.
REQ-020 SHALL drive acc_en as frame_de AND (state==ACCUM), combinationally, with zero latency.
REQ-021 SHALL leave ACCUM for SWEEP on the frame_vs falling edge.
REQ-022 SHALL, in SWEEP, assert sweep_en for exactly BINS consecutive cycles, with sweep_addr running 0..BINS-1, then enter DRAIN.
REQ-023 SHALL hold DRAIN for exactly PIPE_LAT cycles, then enter CLEAR.
REQ-024 SHALL, in CLEAR, assert clr_en for exactly BINS cycles, with clr_addr running 0..BINS-1, then enter SWAP.
REQ-025 SHALL, in SWAP, lasting 1 cycle, toggle lut_bank, set lut_valid sticky, then enter WAIT_FRAME.
REQ-026 SHALL detect a frame_vs rising edge outside WAIT_FRAME as an overrun: pulse overrun, complete the current sequence unchanged, and drop that frame (acc_en stays low for it).
REQ-027 SHALL not enter ACCUM mid-frame: if frame_vs is already high when WAIT_FRAME is entered, it waits for the next rising edge.
REQ-028 SHALL hold sweep_addr and clr_addr at 0 when not in their strobed states.
REQ-029 SHALL let sweep_addr wrap from BINS-1 to 0 only at the SWEEP exit; the counter is 8 bits and BINS is at most 256.

Reset
REQ-030 SHALL, on rst_n low, asynchronously force state=WAIT_FRAME, all counters=0, lut_bank=0, lut_valid=0, overrun=0, and all strobes=0.
REQ-031 SHALL, on reset mid-sequence, abandon the sequence; the histogram RAM is not cleared by this block, so the first post-reset frame is documented as dirty and lut_valid stays 0 until the first SWAP.

Configuration
REQ-032 SHALL, with HIST_CTRL_STATS_EN defined, increment frame_cnt (wrapping) at each SWAP and increment overrun_cnt (saturating at 255) on each overrun pulse.
REQ-033 SHALL, without HIST_CTRL_STATS_EN, drive frame_cnt and overrun_cnt constant 0 and synthesise no counter logic.

Structure
REQ-034 SHALL take the state enum, BINS default and width constants from shared package hist_pkg.
REQ-035 SHALL instantiate one sub-module hist_edge_det, providing the registered rise and fall pulses of frame_vs.

Verification
REQ-036 SHALL cover this case: reset, then frame_vs high for 1000 cycles with frame_de toggling, then low for 600 -> acc_en mirrors frame_de only inside the frame; sweep_en high 256 cycles, 1 cycle after the fall edge.
REQ-037 SHALL cover this case: PIPE_LAT=4 -> clr_en rises exactly 260 cycles after the first sweep_en; lut_bank toggles 0->1 exactly 256 cycles later; lut_valid goes 1.
REQ-038 SHALL cover this case: frame gap of 300 cycles (less than 517) -> overrun pulses once at the next rise; that frame produces no acc_en; the sequence still completes.
REQ-039 SHALL cover this case: assert rst_n low at sweep_addr=100 -> all outputs 0 next cycle; after release, no sweep until a full frame is seen.
REQ-040 SHALL cover this case: HIST_CTRL_STATS_EN with 3 clean frames and 1 overrun -> frame_cnt=3, overrun_cnt=1; without the macro, both read 0.
REQ-041 SHALL cover this case: frame_vs high at reset release -> no ACCUM until the falling then rising edge.

Source files
------------

// File: rtl/hist_pkg.sv
// Shared types and constants for the histogram-equalisation frame controller.
package hist_pkg;

  localparam int BINS_DEF = 256;
  localparam int ADDR_W   = 8;
  localparam int FCNT_W   = 16;
  localparam int OCNT_W   = 8;

  typedef enum logic [2:0] {
    WAIT_FRAME = 3'd0,
    ACCUM      = 3'd1,
    SWEEP      = 3'd2,
    DRAIN      = 3'd3,
    CLEAR      = 3'd4,
    SWAP       = 3'd5
  } hist_state_e;

endpackage

// File: rtl/hist_edge_det.sv
// Rise/fall detector for frame_vs, built from a one-cycle-registered copy.
module hist_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sig,
  output logic o_rise,
  output logic o_fall
);

  logic r_sig_d;

  // Reset to 1 so a frame already active at reset release is not taken as a rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sig_d <= 1'b1;
    else        r_sig_d <= i_sig;
  end

  assign o_rise = i_sig & ~r_sig_d;
  assign o_fall = ~i_sig & r_sig_d;

endmodule

// File: rtl/hist_frame_ctrl.sv
// Frame sequencer: accumulate, CDF sweep, pipeline drain, RAM clear, LUT bank swap.
// Optional statistics counters are built only when HIST_CTRL_STATS_EN is defined.
module hist_frame_ctrl
  import hist_pkg::*;
#(
  parameter int PIPE_LAT = 4,
  parameter int BINS     = BINS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_vs,
  input  logic              frame_de,
  output logic              acc_en,
  output logic              sweep_en,
  output logic [ADDR_W-1:0] sweep_addr,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              lut_bank,
  output logic              lut_valid,
  output logic              busy,
  output logic              overrun,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic [OCNT_W-1:0] overrun_cnt,
  output hist_state_e       dbg_state
);

  localparam int                DRAIN_W    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [ADDR_W-1:0] LAST_BIN   = ADDR_W'(BINS - 1);
  localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(PIPE_LAT - 1);

  hist_state_e        r_state;
  logic               r_sweep_en;
  logic [ADDR_W-1:0]  r_sweep_addr;
  logic               r_clr_en;
  logic [ADDR_W-1:0]  r_clr_addr;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic               r_lut_bank;
  logic               r_lut_valid;
  logic               r_overrun;
  logic               w_rise;
  logic               w_fall;
  logic               w_overrun;

  hist_edge_det u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_sig  (frame_vs),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  // A new frame outside WAIT_FRAME is dropped; the running sequence is untouched.
  assign w_overrun = w_rise && (r_state != WAIT_FRAME);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= WAIT_FRAME;
      r_sweep_en   <= 1'b0;
      r_sweep_addr <= '0;
      r_clr_en     <= 1'b0;
      r_clr_addr   <= '0;
      r_drain_cnt  <= '0;
      r_lut_bank   <= 1'b0;
      r_lut_valid  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_overrun <= w_overrun;
      case (r_state)
        WAIT_FRAME: if (w_rise) r_state <= ACCUM;
        ACCUM: begin
          if (w_fall) begin
            r_state      <= SWEEP;
            r_sweep_en   <= 1'b1;
            r_sweep_addr <= '0;
          end
        end
        SWEEP: begin
          if (r_sweep_addr == LAST_BIN) begin
            r_state      <= DRAIN;
            r_sweep_en   <= 1'b0;
            r_sweep_addr <= '0;
            r_drain_cnt  <= '0;
          end else begin
            r_sweep_addr <= r_sweep_addr + 1'b1;
          end
        end
        DRAIN: begin
          if (r_drain_cnt == LAST_DRAIN) begin
            r_state    <= CLEAR;
            r_clr_en   <= 1'b1;
            r_clr_addr <= '0;
          end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
          end
        end
        CLEAR: begin
          if (r_clr_addr == LAST_BIN) begin
            r_state     <= SWAP;
            r_clr_en    <= 1'b0;
            r_clr_addr  <= '0;
            r_lut_bank  <= ~r_lut_bank;
            r_lut_valid <= 1'b1;
          end else begin
            r_clr_addr <= r_clr_addr + 1'b1;
          end
        end
        SWAP:    r_state <= WAIT_FRAME;
        default: r_state <= WAIT_FRAME;
      endcase
    end
  end

`ifdef HIST_CTRL_STATS_EN
  logic [FCNT_W-1:0] r_frame_cnt;
  logic [OCNT_W-1:0] r_overrun_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt   <= '0;
      r_overrun_cnt <= '0;
    end else begin
      if (r_state == CLEAR && r_clr_addr == LAST_BIN) r_frame_cnt <= r_frame_cnt + 1'b1;
      if (w_overrun && r_overrun_cnt != {OCNT_W{1'b1}}) r_overrun_cnt <= r_overrun_cnt + 1'b1;
    end
  end

  assign frame_cnt   = r_frame_cnt;
  assign overrun_cnt = r_overrun_cnt;
`else
  assign frame_cnt   = '0;
  assign overrun_cnt = '0;
`endif

  assign acc_en     = frame_de && (r_state == ACCUM);
  assign sweep_en   = r_sweep_en;
  assign sweep_addr = r_sweep_addr;
  assign clr_en     = r_clr_en;
  assign clr_addr   = r_clr_addr;
  assign lut_bank   = r_lut_bank;
  assign lut_valid  = r_lut_valid;
  assign overrun    = r_overrun;
  assign busy       = (r_state != WAIT_FRAME) && (r_state != ACCUM);
  assign dbg_state  = r_state;

endmodule
